// File: rtl/reaction_ms_counter_if.sv
// Handshake/status bundle for the reaction-time millisecond counter.
// master = top-level FSM side, slave = counter side.
interface reaction_ms_counter_if;
    logic       enable;
    logic       start;
    logic       stop_n;
    logic [3:0] score_a;
    logic [3:0] score_b;
    logic [3:0] score_c;
    logic       running;
    logic       score_valid;
    logic       done;
    logic       timeout;

    modport master (
        output enable, start, stop_n,
        input  score_a, score_b, score_c,
        input  running, score_valid, done, timeout
    );

    modport slave (
        input  enable, start, stop_n,
        output score_a, score_b, score_c,
        output running, score_valid, done, timeout
    );
endinterface

// File: rtl/reaction_ms_counter.sv
// Reaction timer: prescaler, stop-key sync/edge detect, 3-digit BCD score.
// Optional REACTION_AUTO_TIMEOUT_EN: saturating tick ends the run with timeout.
module reaction_ms_counter #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    reaction_ms_counter_if.slave bus
);
    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);
    localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    dig_a_q, dig_a_d;
    logic [3:0]    dig_b_q, dig_b_d;
    logic [3:0]    dig_c_q, dig_c_d;
    logic          done_q, done_d;
    logic [2:0]    sync_q, sync_d;
    logic          stop_evt;
    logic          tick;
    logic          sat;
`ifdef REACTION_AUTO_TIMEOUT_EN
    logic          timeout_q, timeout_d;
`endif

    // Stop key: two sync stages then one history stage for the fall detect
    always_comb begin
        sync_d = {sync_q[1:0], bus.stop_n};
    end

    assign stop_evt = sync_q[2] & ~sync_q[1];
    assign tick     = (presc_q == DIV_M1);
    assign sat      = (dig_a_q == 4'd9) && (dig_b_q == 4'd9)
                   && (dig_c_q == 4'd9);

    // Run/hold sequencing, prescaler and BCD score update
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        dig_a_d = dig_a_q;
        dig_b_d = dig_b_q;
        dig_c_d = dig_c_q;
        done_d  = 1'b0;
`ifdef REACTION_AUTO_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.enable && bus.start) begin
                    state_d = S_RUN;
                    presc_d = '0;
                    dig_a_d = 4'd0;
                    dig_b_d = 4'd0;
                    dig_c_d = 4'd0;
                end
            end
            S_RUN: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    dig_a_d = 4'd0;
                    dig_b_d = 4'd0;
                    dig_c_d = 4'd0;
                end else if (stop_evt) begin
                    // stop beats a coincident tick: that tick is not scored
                    state_d = S_HOLD;
                    done_d  = 1'b1;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        if (!sat) begin
                            if (dig_c_q == 4'd9) begin
                                dig_c_d = 4'd0;
                                if (dig_b_q == 4'd9) begin
                                    dig_b_d = 4'd0;
                                    dig_a_d = dig_a_q + 4'd1;
                                end else begin
                                    dig_b_d = dig_b_q + 4'd1;
                                end
                            end else begin
                                dig_c_d = dig_c_q + 4'd1;
                            end
                        end
`ifdef REACTION_AUTO_TIMEOUT_EN
                        else begin
                            state_d   = S_HOLD;
                            done_d    = 1'b1;
                            timeout_d = 1'b1;
                        end
`endif
                    end
                end
            end
            S_HOLD: begin
                // digits stay visible after leaving HOLD for downstream readers
                if (!bus.enable) begin
                    state_d = S_IDLE;
`ifdef REACTION_AUTO_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
`ifdef REACTION_AUTO_TIMEOUT_EN
                timeout_d = 1'b0;
`endif
            end
        endcase
    end

    // State, score and synchroniser registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            dig_a_q <= 4'd0;
            dig_b_q <= 4'd0;
            dig_c_q <= 4'd0;
            done_q  <= 1'b0;
            sync_q  <= 3'b111;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            dig_a_q <= dig_a_d;
            dig_b_q <= dig_b_d;
            dig_c_q <= dig_c_d;
            done_q  <= done_d;
            sync_q  <= sync_d;
        end
    end

`ifdef REACTION_AUTO_TIMEOUT_EN
    // Timeout flag, held for the whole HOLD it caused
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.score_a     = dig_a_q;
    assign bus.score_b     = dig_b_q;
    assign bus.score_c     = dig_c_q;
    assign bus.running     = (state_q == S_RUN);
    assign bus.score_valid = (state_q == S_HOLD);
    assign bus.done        = done_q;
endmodule

// File: tb/tb_reaction_ms_counter.sv
// Bench for reaction_ms_counter: directed scenarios plus random stimulus,
// all checked every cycle against a score model built from tick arithmetic.
module tb_reaction_ms_counter;
    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    bit   chk_en = 1'b0;

    reaction_ms_counter_if bus ();

    reaction_ms_counter #(
        .CLK_HZ (1000),
        .TICK_HZ(100)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // model state: 0 idle, 1 run, 2 hold
    int m_mode = 0;
    int m_start = 0;
    int m_score = 0;
    bit m_done = 1'b0;
    bit m_to = 1'b0;
    bit pins[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at t=%0t",
                      name, act, exp, $time);
    endtask

    function automatic logic [15:0] dut_outs();
        return {bus.score_a, bus.score_b, bus.score_c,
                bus.running, bus.score_valid, bus.done, bus.timeout};
    endfunction

    function automatic logic [15:0] exp_outs();
        logic [3:0] a, b, c;
        a = 4'(m_score / 100);
        b = 4'((m_score / 10) % 10);
        c = 4'(m_score % 10);
        return {a, b, c, m_mode == 1, m_mode == 2, m_done, m_to};
    endfunction

    function automatic logic [11:0] dig();
        return {bus.score_a, bus.score_b, bus.score_c};
    endfunction

    // Reference model: score = ticks elapsed since start, ticks every DIV
    // cycles; stop event = pin high 3 cycles ago and low 2 cycles ago.
    initial begin
        int p, n;
        bit evt;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode = 0; m_score = 0; m_done = 0; m_to = 0;
                pins = {1'b1, 1'b1, 1'b1, 1'b1};
            end else begin
                p = cyc;
                pins.push_back(bus.stop_n);
                void'(pins.pop_front());
                evt = pins[0] & ~pins[1];
                m_done = 1'b0;
                case (m_mode)
                    0: if (bus.enable && bus.start) begin
                        m_mode = 1; m_start = p; m_score = 0;
                    end
                    1: if (!bus.enable) begin
                        m_mode = 0; m_score = 0;
                    end else if (evt) begin
                        m_mode = 2; m_done = 1'b1;
                        n = (p - 1 - m_start) / DIV;
                        m_score = (n > 999) ? 999 : n;
                    end else begin
                        n = (p - m_start) / DIV;
`ifdef REACTION_AUTO_TIMEOUT_EN
                        if (n >= 1000) begin
                            m_mode = 2; m_done = 1'b1; m_to = 1'b1;
                            m_score = 999;
                        end else
`endif
                        m_score = (n > 999) ? 999 : n;
                    end
                    2: if (!bus.enable) begin
                        m_mode = 0; m_to = 1'b0;
                    end
                    default: m_mode = 0;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) check("cycle_outs", 32'(dut_outs()), 32'(exp_outs()));
        end
    end

    task automatic restart(output int s);
        @(negedge clk);
        bus.enable = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        bus.enable = 1'b1; bus.start = 1'b1; s = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic stop_at(input int s, input int fall, output int doff);
        while (cyc < s + fall) @(negedge clk);
        bus.stop_n = 1'b0;
        doff = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done && doff < 0) doff = cyc - s;
        end
        bus.stop_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int s, d;
        bus.enable = 1'b0; bus.start = 1'b0; bus.stop_n = 1'b1;
        pins = {1'b1, 1'b1, 1'b1, 1'b1};
        #1 rst_n = 1'b0;
        #2 check("reset_state", 32'(dut_outs()), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // basic score 0,1,2 with done at cycle 128
        restart(s);
        stop_at(s, 125, d);
        check("t2_done_cycle", d, 128);
        check("t2_digits", 32'(dig()), 32'h012);
        check("t2_valid", 32'(bus.score_valid), 32'h1);
        repeat (30) @(negedge clk);
        check("t2_frozen", 32'(dig()), 32'h012);

        // carries into hundreds
        restart(s);
        stop_at(s, 1003, d);
        check("t3_digits", 32'(dig()), 32'h100);

        // stop on a tick cycle drops that tick
        restart(s);
        stop_at(s, 78, d);
        check("t4_done_cycle", d, 81);
        check("t4_digits", 32'(dig()), 32'h007);

        // abort in RUN clears, abort in HOLD retains
        restart(s);
        while (cyc < s + 425) @(negedge clk);
        check("t5_pre_abort", 32'(dig()), 32'h042);
        bus.enable = 1'b0;
        @(negedge clk);
        check("t5_abort", 32'(dut_outs()), 32'h0);
        restart(s);
        stop_at(s, 55, d);
        check("t5_hold_digits", 32'(dig()), 32'h005);
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_hold_keep", 32'({dig(), bus.score_valid}), 32'({12'h005, 1'b0}));

        // asynchronous reset mid-run, checked between clock edges
        restart(s);
        repeat (37) @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check("t1_async_reset", 32'(dut_outs()), 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // saturation
        restart(s);
        d = -1;
        while (cyc < s + 11001) begin
            @(negedge clk);
            if (bus.done && d < 0) d = cyc - s;
        end
`ifdef REACTION_AUTO_TIMEOUT_EN
        check("t6_done_cycle", d, 10001);
        check("t6_state", 32'({dig(), bus.running, bus.score_valid, bus.timeout}),
              32'({12'h999, 3'b011}));
`else
        check("t6_no_done", d, -1);
        check("t6_state", 32'({dig(), bus.running, bus.score_valid, bus.timeout}),
              32'({12'h999, 3'b100}));
`endif

        // random enable drops, start pulses and key bounce
        bus.enable = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            bus.enable = ($urandom_range(0, 199) != 0);
            bus.start = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 29) == 0) bus.stop_n = ~bus.stop_n;
        end
        bus.start = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
